// File: rtl/serial_adder_pkg.sv
// Shared types and helpers for the serial adder/subtractor core.
//   state_t  : control FSM encoding (IDLE, RUN, DONE)
//   MODE_*   : values of the sub input
//   clog2    : ceiling log2, used to size the digit counter
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned v = 1; v < n; v = v << 1) begin
      r++;
    end
    return r;
  endfunction

endpackage

// File: rtl/serial_adder_core_digit_adder.sv
// DIGIT-bit combinational ripple-carry adder built from full-adder cells.
//   a, b      : DIGIT-bit addends
//   cin       : carry into bit 0
//   s         : DIGIT-bit sum
//   cout      : carry out of the top bit
//   c_msb_in  : carry into the top bit (for signed overflow detection)
module digit_adder #(
  parameter int unsigned DIGIT = 1
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             cin,
  output logic [DIGIT-1:0] s,
  output logic             cout,
  output logic             c_msb_in
);

  logic [DIGIT:0] c;

  always_comb begin
    c    = '0;
    s    = '0;
    c[0] = cin;
    for (int unsigned i = 0; i < DIGIT; i++) begin
      s[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
  end

  assign cout     = c[DIGIT];
  assign c_msb_in = c[DIGIT-1];

endmodule

// File: rtl/serial_adder_core.sv
// Multi-cycle adder/subtractor: processes DIGIT bits of two WIDTH-bit
// operands per enabled cycle, LSB first, with the carry held in a register.
//   clk, rst_n          : clock (rising edge), async active-low reset
//   ena                 : global enable, 0 freezes all state
//   in_valid/in_ready   : operand handshake (a, b, cin, sub)
//   sub                 : 0 -> a+b+cin, 1 -> a-b-cin
//   out_valid/out_ready : result handshake (sum, cout, overflow)
//   cout                : carry-out on add, NOT borrow on subtract
//   overflow            : two's-complement signed overflow
module serial_adder_core
  import serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  if (WIDTH < 1 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_params
    $fatal(1, "serial_adder_core: WIDTH must be a nonzero multiple of DIGIT");
  end

  localparam int unsigned NDIG = WIDTH / DIGIT;
  localparam int unsigned CW   = clog2(NDIG) + 1;

  state_t           state, state_nx;
  logic [WIDTH-1:0] a_sh, b_sh, res_sh, res_nx;
  logic             carry;
  logic [CW-1:0]    count;
  logic [DIGIT-1:0] d_s;
  logic             d_cout, d_cmsb;
  logic             last;

  digit_adder #(.DIGIT(DIGIT)) u_digit (
    .a        (a_sh[DIGIT-1:0]),
    .b        (b_sh[DIGIT-1:0]),
    .cin      (carry),
    .s        (d_s),
    .cout     (d_cout),
    .c_msb_in (d_cmsb)
  );

  assign last = (count == CW'(NDIG - 1));

  // New digit enters at the top; shift form stays legal when DIGIT == WIDTH.
  assign res_nx = (res_sh >> DIGIT) | (WIDTH'(d_s) << (WIDTH - DIGIT));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else if (ena) begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (in_valid)  state_nx = RUN;
      RUN:     if (last)      state_nx = DONE;
      DONE:    if (out_ready) state_nx = IDLE;
      default:                state_nx = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
  end

  // Subtraction is a + ~b + ~cin: invert b and the carry-in at accept time.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh     <= '0;
      b_sh     <= '0;
      res_sh   <= '0;
      carry    <= 1'b0;
      count    <= '0;
      sum      <= '0;
      cout     <= 1'b0;
      overflow <= 1'b0;
    end else if (ena) begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_sh  <= a;
            b_sh  <= (sub == MODE_SUB) ? ~b : b;
            carry <= cin ^ sub;
            count <= '0;
          end
        end
        RUN: begin
          a_sh   <= a_sh >> DIGIT;
          b_sh   <= b_sh >> DIGIT;
          res_sh <= res_nx;
          carry  <= d_cout;
          count  <= count + 1'b1;
          if (last) begin
            sum      <= res_nx;
            cout     <= d_cout;
            overflow <= d_cout ^ d_cmsb;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder_core.sv
module tb_serial_adder_core;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        sub;
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ena = 1'b0;
  always #5 clk = ~clk;

  logic       iv8, ir8, ov8, or8, cin8, sub8, cout8, ovf8;
  logic [7:0] a8, b8, s8;
  logic        iv16, ir16, ov16, or16, cin16, sub16, cout16, ovf16;
  logic [15:0] a16, b16, s16;

  serial_adder_core #(.WIDTH(8), .DIGIT(1)) dut8 (
    .clk(clk), .rst_n(rst_n), .ena(ena),
    .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8), .cin(cin8), .sub(sub8),
    .out_valid(ov8), .out_ready(or8), .sum(s8), .cout(cout8), .overflow(ovf8)
  );

  serial_adder_core #(.WIDTH(16), .DIGIT(4)) dut16 (
    .clk(clk), .rst_n(rst_n), .ena(ena),
    .in_valid(iv16), .in_ready(ir16), .a(a16), .b(b16), .cin(cin16), .sub(sub16),
    .out_valid(ov16), .out_ready(or16), .sum(s16), .cout(cout16), .overflow(ovf16)
  );

  int   checks = 0;
  int   errors = 0;
  vec_t q8[$];
  vec_t q16[$];
  vec_t tbl[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Reference built from signed/unsigned integer arithmetic.
  function automatic vec_t model16(input logic [15:0] a, input logic [15:0] b,
                                   input logic cin, input logic sub);
    vec_t        v;
    int          r;
    logic [16:0] u;
    v.a = a; v.b = b; v.cin = cin; v.sub = sub;
    if (!sub) begin
      u      = {1'b0, a} + {1'b0, b} + 17'(cin);
      r      = int'($signed(a)) + int'($signed(b)) + int'(cin);
      v.cout = u[16];
    end else begin
      u      = {1'b0, a} - {1'b0, b} - 17'(cin);
      r      = int'($signed(a)) - int'($signed(b)) - int'(cin);
      v.cout = ({1'b0, a} >= ({1'b0, b} + 17'(cin)));
    end
    v.sum = u[15:0];
    v.ovf = (r > 32767) || (r < -32768);
    return v;
  endfunction

  task automatic pop8();
    vec_t e;
    if (q8.size() == 0) begin
      check("sb8 nonempty", 0, 1);
    end else begin
      e = q8.pop_front();
      check("sum8", s8, e.sum[7:0]);
      check("cout8", cout8, e.cout);
      check("ovf8", ovf8, e.ovf);
    end
  endtask

  task automatic pop16();
    vec_t e;
    if (q16.size() == 0) begin
      check("sb16 nonempty", 0, 1);
    end else begin
      e = q16.pop_front();
      check("sum16", s16, e.sum);
      check("cout16", cout16, e.cout);
      check("ovf16", ovf16, e.ovf);
    end
  endtask

  // hold: cycles of out_ready=0 in DONE with junk operands offered
  // gap : cycles of ena=0 starting two cycles into RUN
  task automatic op8(input vec_t v, input int hold, input int gap);
    int n, lat;
    a8 = v.a[7:0]; b8 = v.b[7:0]; cin8 = v.cin; sub8 = v.sub; iv8 = 1'b1;
    n = 0;
    while (!ir8 && n < 50) begin cyc(1); n++; end
    check("in_ready8 idle", ir8, 1);
    cyc(1);
    iv8 = 1'b0;
    q8.push_back(v);
    check("in_ready8 run", ir8, 0);
    lat = 0;
    while (!ov8 && lat < 100) begin
      ena = !(lat >= 2 && lat < 2 + gap);
      cyc(1);
      lat++;
    end
    ena = 1'b1;
    check("latency8", lat, 8 + gap);
    pop8();
    for (int i = 0; i < hold; i++) begin
      iv8 = 1'b1; a8 = 8'hAA; b8 = 8'h33; or8 = 1'b0;
      cyc(1);
      check("hold out_valid8", ov8, 1);
      check("hold in_ready8", ir8, 0);
      check("hold sum8", s8, v.sum[7:0]);
    end
    iv8 = 1'b1; a8 = 8'h55; or8 = 1'b1;
    cyc(1);
    iv8 = 1'b0; or8 = 1'b0;
    check("out_valid8 after take", ov8, 0);
    check("in_ready8 after take", ir8, 1);
    check("sum8 kept", s8, v.sum[7:0]);
  endtask

  task automatic op16(input vec_t v);
    int n, lat;
    a16 = v.a; b16 = v.b; cin16 = v.cin; sub16 = v.sub; iv16 = 1'b1;
    n = 0;
    while (!ir16 && n < 50) begin cyc(1); n++; end
    cyc(1);
    iv16 = 1'b0;
    q16.push_back(v);
    lat = 0;
    while (!ov16 && lat < 50) begin cyc(1); lat++; end
    check("latency16", lat, 4);
    pop16();
    or16 = 1'b1;
    cyc(1);
    or16 = 1'b0;
    check("in_ready16 after take", ir16, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    iv8 = 0; or8 = 0; a8 = '0; b8 = '0; cin8 = 0; sub8 = 0;
    iv16 = 0; or16 = 0; a16 = '0; b16 = '0; cin16 = 0; sub16 = 0;

    //          a        b        cin   sub   sum      cout  ovf
    tbl[0] = '{16'h000F, 16'h0001, 1'b0, 1'b0, 16'h0010, 1'b0, 1'b0};
    tbl[1] = '{16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
    tbl[2] = '{16'h007F, 16'h0001, 1'b0, 1'b0, 16'h0080, 1'b0, 1'b1};
    tbl[3] = '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'h00FE, 1'b0, 1'b0};
    tbl[4] = '{16'h0080, 16'h0001, 1'b0, 1'b1, 16'h007F, 1'b1, 1'b1};
    tbl[5] = '{16'h0080, 16'h0080, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
    tbl[6] = '{16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0001, 1'b0, 1'b0};
    tbl[7] = '{16'h0005, 16'h0005, 1'b1, 1'b1, 16'h00FF, 1'b0, 1'b0};
    tbl[8] = '{16'h007F, 16'h007F, 1'b1, 1'b0, 16'h00FF, 1'b0, 1'b1};
    tbl[9] = '{16'h007F, 16'h00FF, 1'b0, 1'b1, 16'h0080, 1'b0, 1'b1};

    ena = 1'b1;
    cyc(2);
    check("reset in_ready8", ir8, 1);
    check("reset out_valid8", ov8, 0);
    check("reset sum8", s8, 0);
    check("reset cout8", cout8, 0);
    check("reset ovf8", ovf8, 0);
    check("reset out_valid16", ov16, 0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc(1);

    for (int i = 0; i < 10; i++) op8(tbl[i], 0, 0);

    op8(tbl[1], 5, 0);   // backpressure in DONE
    op8(tbl[2], 0, 4);   // ena low mid-RUN

    // Reset mid-RUN at count==3: outputs return to reset values at once.
    a8 = 8'h12; b8 = 8'h34; cin8 = 0; sub8 = 0; iv8 = 1'b1;
    cyc(1);
    iv8 = 1'b0;
    cyc(3);
    rst_n = 1'b0;
    #1;
    check("midrun rst in_ready8", ir8, 1);
    check("midrun rst out_valid8", ov8, 0);
    check("midrun rst sum8", s8, 0);
    check("midrun rst ovf8", ovf8, 0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc(1);
    check("post rst out_valid8", ov8, 0);
    op8(tbl[0], 0, 0);

    op16('{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0});
    for (int i = 0; i < 1000; i++) begin
      op16(model16(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom)));
    end

    check("sb8 drained", q8.size(), 0);
    check("sb16 drained", q16.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
